// File: rtl/i2c_link_pkg.sv
// -----------------------------------------------------------------------------
// i2c_link_pkg
// Shared types and helpers for the i2c_link two-wire word link.
//   tx_state_e    : transmitter FSM states
//   rx_state_e    : receiver framing states
//   frame_cycles  : sclk cycles from START entry to IDLE re-entry
//   params_legal  : legality of the DATA_W / CLK_DIV parameter pair
// -----------------------------------------------------------------------------
package i2c_link_pkg;

    localparam int MAX_DATA_W  = 8;
    localparam int MAX_CLK_DIV = 255;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_BIT_LO  = 3'd2,
        TX_BIT_HI  = 3'd3,
        TX_STOP_LO = 3'd4,
        TX_STOP_HI = 3'd5
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    // START + two half-periods per bit + STOP_LO + STOP_HI, each CLK_DIV long.
    function automatic int frame_cycles(input int data_w, input int clk_div);
        return clk_div * (2 * data_w + 3);
    endfunction

    function automatic bit params_legal(input int data_w, input int clk_div);
        return (data_w >= 1) && (data_w <= MAX_DATA_W) &&
               (clk_div >= 1) && (clk_div <= MAX_CLK_DIV);
    endfunction

endpackage

// File: rtl/i2c_link_rx.sv
// -----------------------------------------------------------------------------
// i2c_link_rx
// Two-wire receiver: detects start/stop conditions and data clocks on
// scl_i/sda_i, assembles a DATA_W-bit word MSB first and publishes it as a
// one-hot vector. Usable standalone as a bus monitor.
// Ports:
//   sclk, rst          system clock, async active-low reset
//   scl_i, sda_i       observed bus lines
//   outhigh            one-hot of the last well-formed word (bit[word] set)
//   out_valid          one-cycle pulse when outhigh updates
//   frame_err          one-cycle pulse on a short/long frame or repeated start
//   dbg_state          current framing state
// -----------------------------------------------------------------------------
module i2c_link_rx
    import i2c_link_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic [2**DATA_W-1:0]   outhigh,
    output logic                   out_valid,
    output logic                   frame_err,
    output rx_state_e              dbg_state
);

    localparam int OUT_W = 2**DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 2);

    logic              r_scl;
    logic              r_sda;
    rx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_bit;
    logic              r_pend;

    // Current line values are compared against last cycle's registered copy.
    // Start/stop require scl high in both samples so that a data bit whose
    // sda change lands in the same cycle as the scl rise is not mistaken
    // for a bus condition.
    logic w_start;
    logic w_stop;
    logic w_rise;
    logic w_fall;

    assign w_start = r_scl &  scl_i &  r_sda & ~sda_i;
    assign w_stop  = r_scl &  scl_i & ~r_sda &  sda_i;
    assign w_rise  = ~r_scl & scl_i;
    assign w_fall  = r_scl & ~scl_i;

    assign dbg_state = r_state;

    // A bit is sampled on the scl rise and only committed on the following
    // scl fall. The clock pulse that precedes a stop (or a repeated start)
    // therefore never reaches the shift register or the count.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit     <= 1'b0;
            r_pend    <= 1'b0;
            outhigh   <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_scl     <= scl_i;
            r_sda     <= sda_i;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (w_start) begin
                if (r_state == RX_RECV) begin
                    frame_err <= 1'b1;
                end
                r_state <= RX_RECV;
                r_cnt   <= '0;
                r_shift <= '0;
                r_pend  <= 1'b0;
            end else if (r_state == RX_RECV) begin
                if (w_stop) begin
                    if (r_cnt == CNT_W'(DATA_W)) begin
                        outhigh   <= OUT_W'(1) << r_shift;
                        out_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    r_state <= RX_IDLE;
                    r_pend  <= 1'b0;
                end else if (w_rise) begin
                    r_bit  <= sda_i;
                    r_pend <= 1'b1;
                end else if (w_fall && r_pend) begin
                    r_shift <= DATA_W'({r_shift, r_bit});
                    r_pend  <= 1'b0;
                    // Saturate one past a full word so over-long frames stay wrong.
                    if (r_cnt != CNT_W'(DATA_W + 1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/i2c_link.sv
// -----------------------------------------------------------------------------
// i2c_link
// Word transmitter over a two-wire bus plus the matching receiver.
// Ports:
//   sclk, rst                 system clock, async active-low reset
//   data, data_valid, ack     word input handshake
//   scl_o, sda_o              registered bus lines driven by the transmitter
//   scl_i, sda_i              bus lines seen by the receiver (loop back or route)
//   outhigh, out_valid        one-hot decoded word and its update pulse
//   frame_err                 malformed-frame pulse
//   dbg_tx_state/dbg_rx_state current FSM states
//
// Handshake: a word is transferred on a rising sclk edge where data_valid and
// ack are both high; ack is high exactly while the transmitter is IDLE, drops
// the cycle after the transfer, and data is ignored whenever ack is low.
// -----------------------------------------------------------------------------
module i2c_link
    import i2c_link_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      data,
    input  logic                   data_valid,
    output logic                   ack,
    output logic                   scl_o,
    output logic                   sda_o,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic [2**DATA_W-1:0]   outhigh,
    output logic                   out_valid,
    output logic                   frame_err,
    output tx_state_e              dbg_tx_state,
    output rx_state_e              dbg_rx_state
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (!params_legal(DATA_W, CLK_DIV)) begin : g_bad_params
        $error("i2c_link: DATA_W must be 1..8 and CLK_DIV 1..255");
    end

    tx_state_e         r_state;
    logic [7:0]        r_div;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;

    logic w_div_done;
    logic w_div_first;

    assign w_div_done   = (r_div == 8'(CLK_DIV - 1));
    assign w_div_first  = (r_div == 8'd0);
    assign dbg_tx_state = r_state;

    // scl_o moves on state entry; the data/stop-low value on sda_o is applied
    // in the first cycle of the low phase, one cycle after scl has fallen, so
    // the two lines never switch together when CLK_DIV >= 2.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state <= TX_IDLE;
            r_div   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            scl_o   <= 1'b1;
            sda_o   <= 1'b1;
            ack     <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (data_valid && ack) begin
                        r_data  <= data;
                        r_idx   <= IDX_W'(DATA_W - 1);
                        r_div   <= '0;
                        r_state <= TX_START;
                        sda_o   <= 1'b0;
                        ack     <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= TX_BIT_LO;
                        scl_o   <= 1'b0;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                TX_BIT_LO: begin
                    if (w_div_first) begin
                        sda_o <= r_data[r_idx];
                    end
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= TX_BIT_HI;
                        scl_o   <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                TX_BIT_HI: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        scl_o <= 1'b0;
                        if (r_idx == '0) begin
                            r_state <= TX_STOP_LO;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= TX_BIT_LO;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                TX_STOP_LO: begin
                    if (w_div_first) begin
                        sda_o <= 1'b0;
                    end
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= TX_STOP_HI;
                        scl_o   <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                TX_STOP_HI: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= TX_IDLE;
                        sda_o   <= 1'b1;   // stop condition
                        ack     <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_div   <= '0;
                    r_state <= TX_IDLE;
                    scl_o   <= 1'b1;
                    sda_o   <= 1'b1;
                    ack     <= 1'b1;
                end
            endcase
        end
    end

    i2c_link_rx #(
        .DATA_W (DATA_W)
    ) u_rx (
        .sclk      (sclk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .outhigh   (outhigh),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .dbg_state (dbg_rx_state)
    );

endmodule
